apb_slave_regbank: RTL and testbench
====================================

# apb_slave_regbank

APB4 completer holding a byte-enabled storage array plus two control registers, with run-time programmable wait states and PSLVERR generation. It sits directly downstream of the AHB-to-APB bridge's APB master port and is the default completer used to exercise multi-beat, wait-state and error paths of that bridge. Single clock domain (PCLK).

## Interface
- PADDR_SIZE, 10, APB address width
- PDATA_SIZE, 8, APB data width; multiple of 8, ≤ 32
- MEM_DEPTH, 512, number of PDATA_SIZE-wide storage words; must be ≤ 2^(PADDR_SIZE-OFS)-2, OFS = log2(PDATA_SIZE/8)
- ID_VALUE, 'hA5, read-only ID register content
- PRIV_ONLY, 0, 1 = non-privileged accesses (PPROT[0]=0) are rejected

- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- PSEL  in  1  select
- PENABLE  in  1  access phase
- PPROT  in  3  protection; bit0 = privileged
- PWRITE  in  1  1 = write
- PSTRB  in  PDATA_SIZE/8  write byte lanes
- PADDR  in  PADDR_SIZE  byte address
- PWDATA  in  PDATA_SIZE  write data
- PRDATA  out  PDATA_SIZE  read data, valid only while PREADY=1
- PREADY  out  1  transfer complete (registered)
- PSLVERR  out  1  error, valid only while PREADY=1
- WAIT_CYCLES  in  4  wait states inserted per transfer, sampled in setup phase
- ERR_IRQ  out  1  high while error counter ≠ 0 (registered)

## Operation
- Word index IDX = PADDR[PADDR_SIZE-1:OFS]; low OFS bits ignored.
- Map: IDX < MEM_DEPTH → RAM; IDX = MEM_DEPTH → ID (RO); IDX = MEM_DEPTH+1 → ERRCNT (read = count, any write clears); else unmapped.
- Error if: unmapped; write to ID; PRIV_ONLY=1 and PPROT[0]=0. Erroring transfer: no state change except ERRCNT += 1, saturating at all-ones; PRDATA=0, PSLVERR=1.
- Writes: at the completion edge, RAM/ERRCNT byte lanes with PSTRB=1 updated; PSTRB=0 write is a legal no-op. ERRCNT clear requires PSTRB≠0.
- Reads: PSTRB ignored; full word returned.
- FSM (ST_IDLE, ST_WAIT, ST_RESP):
  - ST_IDLE: PSEL & !PENABLE → latch PADDR/PWRITE/PSTRB/PWDATA/PPROT, cnt ← WAIT_CYCLES; cnt=0 → ST_RESP with PREADY←1, else ST_WAIT. PSEL & PENABLE in IDLE ignored.
  - ST_WAIT: cnt decrements each edge; at cnt=1 → ST_RESP, PREADY←1, PRDATA/PSLVERR loaded.
  - ST_RESP: PSEL & PENABLE → commit, PREADY/PSLVERR/PRDATA ← 0, → ST_IDLE.
  - Any state: PSEL=0 (abort) → ST_IDLE, outputs cleared, nothing committed.
- Decode/response use latched control, not live bus.

## Timing
- Reset: PREADY=0, PSLVERR=0, PRDATA=0, ERRCNT=0, ERR_IRQ=0, FSM=ST_IDLE. RAM not reset; contents retained across PRESETn.
- Access phase lasts WAIT_CYCLES+1 cycles; zero-wait transfer = 2 PCLK (setup + access).
- Back-to-back: new setup phase accepted the cycle after completion (PREADY=1 for exactly one cycle per transfer).
- Read-after-write to same word in next transfer returns new data.
- ERR_IRQ follows ERRCNT with one cycle latency; ERRCNT write-clear and increment never coincide (a clear is not itself an error).
- Reset asserted mid-transfer: outputs to reset values immediately, in-flight write dropped.

## Structure
- ahb3lite_pkg: add apb_slv_fsm_states enum and PPROT bit constant reuse; no new package.
- Sub-module apb_slave_ram: MEM_DEPTH×PDATA_SIZE byte-enabled array, synchronous write, combinational read.
- Top holds FSM, wait counter, decode, ERRCNT.

## Test plan
- WAIT_CYCLES=0, write 0x3C to PADDR 0x010, PSTRB=1, read back → PREADY high in 2nd cycle each transfer, PRDATA=0x3C, PSLVERR=0.
- WAIT_CYCLES=3, read PADDR 0x200 (ID) → PREADY asserts 4th access cycle, PRDATA=0xA5.
- Write PADDR 0x200, then read 0x3FF → both PSLVERR=1; read 0x201 → 0x02, ERR_IRQ=1; write 0x201 → next read 0x00, ERR_IRQ=0.
- PRIV_ONLY=1, write PADDR 0x005 with PPROT=3'b000 → PSLVERR=1, RAM unchanged; PPROT=3'b001 → OKAY.
- 256 errors → ERRCNT saturates 0xFF; write with PSTRB=0 to 0x010 → data unchanged.
- PSEL dropped during wait (WAIT_CYCLES=5) on write to 0x020 → no PREADY, RAM unchanged; PRESETn pulse mid-transfer → outputs 0, FSM idle.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite/APB definitions: APB completer FSM states and PPROT bit positions.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_slv_fsm_states;

  localparam int PPROT_PRIVILEGED = 0;

endpackage

// File: rtl/apb_slave_ram.sv
// Byte-enabled storage array: synchronous write, combinational read, no reset.
module apb_slave_ram #(
  parameter int MEM_DEPTH  = 512,
  parameter int PDATA_SIZE = 8,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int SW = PDATA_SIZE / 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [SW-1:0]         be_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [PDATA_SIZE-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [PDATA_SIZE-1:0] rdata_o
);

  logic [PDATA_SIZE-1:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < SW; b++) begin
        if (be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_regbank.sv
// APB4 completer: RAM + read-only ID + saturating error counter, with
// programmable wait states and PSLVERR on unmapped/illegal/unprivileged access.
module apb_slave_regbank
  import ahb3lite_pkg::*;
#(
  parameter int                PADDR_SIZE = 10,
  parameter int                PDATA_SIZE = 8,
  parameter int                MEM_DEPTH  = 512,
  parameter logic [PDATA_SIZE-1:0] ID_VALUE = 'hA5,
  parameter bit                PRIV_ONLY  = 1'b0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [2:0]              PPROT,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [3:0]              WAIT_CYCLES,
  output logic                    ERR_IRQ
);

  localparam int OFS = $clog2(PDATA_SIZE / 8);
  localparam int IW  = PADDR_SIZE - OFS;
  localparam int SW  = PDATA_SIZE / 8;
  localparam int AW  = $clog2(MEM_DEPTH);

  function automatic logic [PDATA_SIZE-1:0] sat_inc(input logic [PDATA_SIZE-1:0] v);
    return (&v) ? v : v + PDATA_SIZE'(1);
  endfunction

  apb_slv_fsm_states     state_q;
  logic [3:0]            cnt_q;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  priv_q, priv_d;
  logic [SW-1:0]         strb_q;
  logic [PDATA_SIZE-1:0] wdata_q;
  logic [PDATA_SIZE-1:0] prdata_q, errcnt_q, rsp_data, ram_rdata;
  logic                  pready_q, pslverr_q, err_irq_q;
  logic                  setup, is_ram, is_id, is_errcnt, rsp_err, ram_we;
  logic                  unused_prot;

  assign setup       = (state_q == ST_IDLE) && PSEL && !PENABLE;
  assign unused_prot = ^PPROT[2:1];

  // In the setup cycle the live bus is decoded so zero-wait responses load on
  // the same edge; afterwards only the latched transfer is used.
  always_comb begin
    idx_d   = idx_q;
    write_d = write_q;
    priv_d  = priv_q;
    if (setup) begin
      idx_d   = PADDR[PADDR_SIZE-1:OFS];
      write_d = PWRITE;
      priv_d  = PPROT[PPROT_PRIVILEGED];
    end
  end

  always_comb begin
    is_ram    = idx_d < IW'(MEM_DEPTH);
    is_id     = idx_d == IW'(MEM_DEPTH);
    is_errcnt = idx_d == IW'(MEM_DEPTH + 1);
    rsp_err   = !(is_ram || is_id || is_errcnt) || (is_id && write_d) ||
                (PRIV_ONLY && !priv_d);
    rsp_data  = '0;
    if (!rsp_err && !write_d) begin
      if (is_ram)     rsp_data = ram_rdata;
      else if (is_id) rsp_data = ID_VALUE;
      else            rsp_data = errcnt_q;
    end
  end

  always_ff @(posedge PCLK) begin
    if (setup) begin
      idx_q   <= idx_d;
      write_q <= write_d;
      priv_q  <= priv_d;
      strb_q  <= PSTRB;
      wdata_q <= PWDATA;
    end
  end

  assign ram_we = (state_q == ST_RESP) && PSEL && PENABLE && !pslverr_q &&
                  write_q && is_ram;

  apb_slave_ram #(
    .MEM_DEPTH  (MEM_DEPTH),
    .PDATA_SIZE (PDATA_SIZE)
  ) u_ram (
    .clk_i   (PCLK),
    .we_i    (ram_we),
    .be_i    (strb_q),
    .waddr_i (idx_q[AW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (idx_d[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      errcnt_q  <= '0;
      err_irq_q <= 1'b0;
    end else begin
      err_irq_q <= (errcnt_q != '0);
      if (!PSEL) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
        prdata_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!PENABLE) begin
              cnt_q <= WAIT_CYCLES;
              if (WAIT_CYCLES == 4'd0) begin
                state_q   <= ST_RESP;
                pready_q  <= 1'b1;
                pslverr_q <= rsp_err;
                prdata_q  <= rsp_data;
              end else begin
                state_q <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= rsp_err;
              prdata_q  <= rsp_data;
            end
          end
          ST_RESP: begin
            if (PENABLE) begin
              state_q   <= ST_IDLE;
              pready_q  <= 1'b0;
              pslverr_q <= 1'b0;
              prdata_q  <= '0;
              // An erroring transfer only counts; a clear is never an error.
              if (pslverr_q)                            errcnt_q <= sat_inc(errcnt_q);
              else if (write_q && is_errcnt && |strb_q) errcnt_q <= '0;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
  assign ERR_IRQ = err_irq_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (PRIV_ONLY 0 and 1) on one bus,
// compared against a behavioural register-map model.
module tb_apb_slave_regbank;

  logic       PCLK = 1'b0;
  logic       PRESETn, PSEL, PENABLE, PWRITE;
  logic [2:0] PPROT;
  logic [0:0] PSTRB;
  logic [9:0] PADDR;
  logic [7:0] PWDATA;
  logic [3:0] WAIT_CYCLES;
  logic [7:0] PRDATA0, PRDATA1;
  logic       PREADY0, PREADY1, PSLVERR0, PSLVERR1, IRQ0, IRQ1;

  always #5 PCLK = ~PCLK;

  apb_slave_regbank #(.PRIV_ONLY(1'b0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA0),
    .PREADY(PREADY0), .PSLVERR(PSLVERR0), .WAIT_CYCLES(WAIT_CYCLES), .ERR_IRQ(IRQ0)
  );

  apb_slave_regbank #(.PRIV_ONLY(1'b1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT),
    .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA1),
    .PREADY(PREADY1), .PSLVERR(PSLVERR1), .WAIT_CYCLES(WAIT_CYCLES), .ERR_IRQ(IRQ1)
  );

  int         tests = 0;
  int         fails = 0;
  logic [7:0] mem_m  [2][512];
  bit         known  [2][512];
  logic [7:0] ecnt_m [2];
  int         klist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-map rules: returns the expected response and applies the commit.
  task automatic model(input int k, input bit wr, input int idx, input logic [7:0] d,
                       input logic s, input logic [2:0] pr,
                       output bit e, output logic [7:0] rd);
    e  = (idx > 513) || (idx == 512 && wr) || (k == 1 && !pr[0]);
    rd = 8'h00;
    if (e) begin
      if (ecnt_m[k] != 8'hFF) ecnt_m[k] = ecnt_m[k] + 8'd1;
    end else if (!wr) begin
      rd = (idx < 512) ? mem_m[k][idx] : (idx == 512) ? 8'hA5 : ecnt_m[k];
    end else if (s) begin
      if (idx < 512) begin
        mem_m[k][idx] = d;
        known[k][idx] = 1'b1;
      end else if (idx == 513) begin
        ecnt_m[k] = 8'h00;
      end
    end
  endtask

  task automatic xfer(input bit wr, input int addr, input logic [7:0] d, input logic s,
                      input logic [2:0] pr, input int w);
    bit         e   [2];
    logic [7:0] rd  [2];
    bit         irq [2];
    bit         kn  [2];
    int         n;
    @(negedge PCLK);
    chk("rdy_idle", {PREADY1, PREADY0}, 2'b00);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr[9:0]; PWDATA = d;
    PSTRB = s; PPROT = pr; WAIT_CYCLES = w[3:0];
    for (int k = 0; k < 2; k++) begin
      irq[k] = (ecnt_m[k] != 8'h00);
      kn[k]  = (addr >= 512) || known[k][addr];
      model(k, wr, addr, d, s, pr, e[k], rd[k]);
    end
    @(negedge PCLK);
    PENABLE = 1'b1;
    n = 1;
    while (PREADY0 !== 1'b1 && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    chk("latency", n, w + 1);
    chk("rdy_dut1", PREADY1, 1'b1);
    chk("pslverr0", PSLVERR0, e[0]);
    chk("pslverr1", PSLVERR1, e[1]);
    if (!wr && kn[0]) chk("prdata0", PRDATA0, rd[0]);
    if (!wr && kn[1]) chk("prdata1", PRDATA1, rd[1]);
    chk("irq0", IRQ0, irq[0]);
    chk("irq1", IRQ1, irq[1]);
  endtask

  task automatic abort_wr(input int addr, input logic [7:0] d, input int w, input int ncyc);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr[9:0]; PWDATA = d;
    PSTRB = 1'b1; PPROT = 3'b001; WAIT_CYCLES = w[3:0];
    for (int i = 0; i < ncyc; i++) begin
      @(negedge PCLK);
      PENABLE = 1'b1;
      chk("abort_wait_rdy", {PREADY1, PREADY0}, 2'b00);
    end
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      chk("abort_rdy", {PREADY1, PREADY0}, 2'b00);
    end
  endtask

  task automatic reset_mid(input bit wr, input int addr, input logic [7:0] d, input int w);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr[9:0]; PWDATA = d;
    PSTRB = 1'b1; PPROT = 3'b001; WAIT_CYCLES = w[3:0];
    @(negedge PCLK);
    PENABLE = 1'b1;
    if (w == 0) chk("rdy_before_rst", PREADY0, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_rdy", {PREADY1, PREADY0}, 2'b00);
    chk("rst_err", {PSLVERR1, PSLVERR0}, 2'b00);
    chk("rst_prdata", {PRDATA1, PRDATA0}, 16'h0000);
    chk("rst_irq", {IRQ1, IRQ0}, 2'b00);
    ecnt_m[0] = 8'h00;
    ecnt_m[1] = 8'h00;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PPROT = 3'b001;
    PSTRB = 1'b1; PADDR = '0; PWDATA = '0; WAIT_CYCLES = '0;
    ecnt_m[0] = 8'h00; ecnt_m[1] = 8'h00;
    repeat (3) @(negedge PCLK);
    chk("reset_rdy", {PREADY1, PREADY0}, 2'b00);
    chk("reset_err", {PSLVERR1, PSLVERR0}, 2'b00);
    chk("reset_prdata", {PRDATA1, PRDATA0}, 16'h0000);
    chk("reset_irq", {IRQ1, IRQ0}, 2'b00);
    PRESETn = 1'b1;

    // Zero-wait write/read of a RAM word
    xfer(1'b1, 'h010, 8'h3C, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h010, 8'h00, 1'b1, 3'b001, 0);

    // Seed RAM words used later
    xfer(1'b1, 'h020, 8'h5A, 1'b1, 3'b001, 1);
    for (int i = 0; i < 16; i++) begin
      int a;
      a = $urandom_range(48, 511);
      klist.push_back(a);
      xfer(1'b1, a, 8'($urandom), 1'b1, 3'b001, $urandom_range(0, 3));
    end

    // ID read with three wait states, then error counting and clearing
    xfer(1'b0, 'h200, 8'h00, 1'b1, 3'b001, 3);
    xfer(1'b1, 'h200, 8'h11, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h3FF, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h201, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b1, 'h201, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h201, 8'h00, 1'b1, 3'b001, 0);

    // Privilege: dut1 rejects the unprivileged write
    xfer(1'b1, 'h005, 8'h11, 1'b1, 3'b001, 0);
    xfer(1'b1, 'h005, 8'h77, 1'b1, 3'b000, 0);
    xfer(1'b0, 'h005, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b1, 'h201, 8'h00, 1'b1, 3'b001, 0);

    // Randomized traffic over the whole map
    for (int i = 0; i < 80; i++) begin
      int r, a;
      r = $urandom_range(0, 9);
      if (r <= 5)      a = klist[$urandom_range(0, klist.size() - 1)];
      else if (r == 6) a = 'h200;
      else if (r == 7) a = 'h201;
      else if (r == 8) a = $urandom_range(514, 1023);
      else             a = $urandom_range(48, 511);
      xfer(1'($urandom), a, 8'($urandom), 1'($urandom), 3'($urandom), $urandom_range(0, 4));
    end

    // Saturation of the error counter, then strobe-less writes are no-ops
    xfer(1'b1, 'h201, 8'h00, 1'b1, 3'b001, 0);
    for (int i = 0; i < 257; i++) xfer(1'b0, 'h3FF, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h201, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b1, 'h010, 8'h99, 1'b0, 3'b001, 0);
    xfer(1'b0, 'h010, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b1, 'h201, 8'h00, 1'b0, 3'b001, 0);
    xfer(1'b0, 'h201, 8'h00, 1'b1, 3'b001, 2);

    // Abort during wait states leaves RAM untouched
    abort_wr('h020, 8'hE7, 5, 3);
    xfer(1'b0, 'h020, 8'h00, 1'b1, 3'b001, 0);

    // Reset in the middle of a response and of a write
    reset_mid(1'b0, 'h200, 8'h00, 0);
    xfer(1'b0, 'h201, 8'h00, 1'b1, 3'b001, 1);
    reset_mid(1'b1, 'h020, 8'hC3, 2);
    xfer(1'b0, 'h020, 8'h00, 1'b1, 3'b001, 0);
    xfer(1'b0, 'h010, 8'h00, 1'b1, 3'b001, 4);

    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
